// File: rtl/regffte_addr_arb_if.sv
// Bus bundle between the FFT/MFCC address sources and the regffte port arbiter.
// master = source side (requests, addresses); slave = arbiter side (grants, RAM port).
interface regffte_addr_arb_if #(
    parameter int NSRC = 2,
    parameter int AW   = 6
);
    localparam int SW = (NSRC > 1) ? $clog2(NSRC) : 1;

    logic [NSRC-1:0]    req;
    logic [NSRC-1:0]    last;
    logic [NSRC*AW-1:0] addr_in;
    logic [NSRC-1:0]    we_in;
    logic [NSRC-1:0]    gnt;
    logic [AW-1:0]      regffte_addr;
    logic               regffte_we;
    logic               regffte_vld;
    logic [SW-1:0]      cur_src;
    logic               addr_err;

    modport master (
        output req, last, addr_in, we_in,
        input  gnt, regffte_addr, regffte_we, regffte_vld, cur_src, addr_err
    );

    modport slave (
        input  req, last, addr_in, we_in,
        output gnt, regffte_addr, regffte_we, regffte_vld, cur_src, addr_err
    );
endinterface

// File: rtl/regffte_addr_arb.sv
// Round-robin burst arbiter for the single regffte RAM port; registered address/we/vld.
// Optional range check on granted addresses enabled by REGFFTE_ARB_ADDR_CHK_EN.
//
// state | meaning
// IDLE  | no owner; pick next requester starting at ptr (grant bubble cycle)
// BUSY  | owner holds port; beats pass until last or idle timeout
module regffte_addr_arb #(
    parameter int NSRC    = 2,
    parameter int AW      = 6,
    parameter int DEPTH   = 64,
    parameter int TIMEOUT = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    regffte_addr_arb_if.slave  bus
);
    localparam int SW = (NSRC > 1) ? $clog2(NSRC) : 1;
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] IDLE_LAST = TW'(TIMEOUT - 1);
    localparam logic [SW-1:0] SRC_LAST  = SW'(NSRC - 1);

    if (NSRC < 2 || TIMEOUT < 1 || DEPTH < 1 || DEPTH > (1 << AW)) begin : g_bad_param
        $error("regffte_addr_arb: illegal parameter combination");
    end

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic [SW-1:0] owner;
    logic [SW-1:0] ptr;
    logic [SW-1:0] winner;
    logic [SW-1:0] ptr_nxt;
    logic [TW-1:0] idle_cnt;
    logic          any_req;
    logic          own_req;
    logic          own_last;
    logic          own_we;
    logic [AW-1:0] own_addr;
    logic          addr_ok;
    logic          rel;
    logic [AW-1:0] addr_q;
    logic          we_q;
    logic          vld_q;

    // Round-robin search starting at ptr, wrapping at NSRC (not at 2**SW)
    always_comb begin
        int cand;
        winner  = ptr;
        any_req = 1'b0;
        cand    = 0;
        for (int i = 0; i < NSRC; i++) begin
            cand = int'(ptr) + i;
            if (cand >= NSRC) begin
                cand = cand - NSRC;
            end
            if (!any_req && bus.req[cand]) begin
                any_req = 1'b1;
                winner  = SW'(cand);
            end
        end
    end

    always_comb begin
        own_req  = 1'b0;
        own_last = 1'b0;
        own_we   = 1'b0;
        own_addr = '0;
        for (int s = 0; s < NSRC; s++) begin
            if (owner == SW'(s)) begin
                own_req  = bus.req[s];
                own_last = bus.last[s];
                own_we   = bus.we_in[s];
                own_addr = bus.addr_in[s*AW +: AW];
            end
        end
    end

    // A dropped (out-of-range) last beat still releases the port
    assign rel     = (state == BUSY) && (own_req ? own_last : (idle_cnt == IDLE_LAST));
    assign ptr_nxt = (owner == SRC_LAST) ? '0 : owner + SW'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (any_req) state_nxt = BUSY;
            BUSY:    if (rel)     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        bus.gnt = '0;
        for (int s = 0; s < NSRC; s++) begin
            if (state == BUSY && owner == SW'(s)) begin
                bus.gnt[s] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            owner    <= '0;
            ptr      <= '0;
            idle_cnt <= '0;
            addr_q   <= '0;
            we_q     <= 1'b0;
            vld_q    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    vld_q    <= 1'b0;
                    we_q     <= 1'b0;
                    idle_cnt <= '0;
                    if (any_req) begin
                        owner <= winner;
                    end
                end
                BUSY: begin
                    if (own_req) begin
                        idle_cnt <= '0;
                        if (addr_ok) begin
                            addr_q <= own_addr;
                            we_q   <= own_we;
                            vld_q  <= 1'b1;
                        end else begin
                            we_q   <= 1'b0;
                            vld_q  <= 1'b0;
                        end
                    end else begin
                        idle_cnt <= idle_cnt + TW'(1);
                        we_q     <= 1'b0;
                        vld_q    <= 1'b0;
                    end
                    if (rel) begin
                        ptr      <= ptr_nxt;
                        idle_cnt <= '0;
                    end
                end
                default: begin
                    vld_q <= 1'b0;
                    we_q  <= 1'b0;
                end
            endcase
        end
    end

`ifdef REGFFTE_ARB_ADDR_CHK_EN
    localparam logic [AW:0] DEPTH_LIM = (AW+1)'(DEPTH);
    logic err_q;

    assign addr_ok = ({1'b0, own_addr} < DEPTH_LIM);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q <= 1'b0;
        end else if (state == BUSY && own_req && !addr_ok) begin
            err_q <= 1'b1;
        end
    end

    assign bus.addr_err = err_q;
`else
    assign addr_ok      = 1'b1;
    assign bus.addr_err = 1'b0;
`endif

    assign bus.regffte_addr = addr_q;
    assign bus.regffte_we   = we_q;
    assign bus.regffte_vld  = vld_q;
    assign bus.cur_src      = owner;
endmodule

// File: tb/tb_regffte_addr_arb.sv
// Bench for regffte_addr_arb: directed scenarios with literal expectations, then random
// traffic compared every cycle against a behavioural arbitration model.
module tb_regffte_addr_arb;
    localparam int NSRC    = 2;
    localparam int AW      = 6;
    localparam int DEPTH   = 48;
    localparam int TIMEOUT = 4;
`ifdef REGFFTE_ARB_ADDR_CHK_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    int   n_chk  = 0;
    int   n_pass = 0;
    bit   cmp_en = 1'b0;

    regffte_addr_arb_if #(.NSRC(NSRC), .AW(AW)) bus ();

    regffte_addr_arb #(
        .NSRC(NSRC), .AW(AW), .DEPTH(DEPTH), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    // Behavioural model: who owns the port, whose turn is next, what the RAM port shows
    bit m_busy, m_we, m_vld, m_err, m_rel;
    int m_owner, m_ptr, m_idle, m_addr, m_s, m_a;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_busy = 0; m_owner = 0; m_ptr = 0; m_idle = 0;
            m_addr = 0; m_we = 0; m_vld = 0; m_err = 0;
        end else if (!m_busy) begin
            m_vld = 0;
            m_we  = 0;
            for (int k = 0; k < NSRC; k++) begin
                m_s = (m_ptr + k) % NSRC;
                if (!m_busy && bus.req[m_s]) begin
                    m_owner = m_s;
                    m_busy  = 1;
                    m_idle  = 0;
                end
            end
        end else begin
            m_rel = 0;
            if (bus.req[m_owner]) begin
                m_idle = 0;
                m_a = int'(bus.addr_in[m_owner*AW +: AW]);
                if (CHK && m_a >= DEPTH) begin
                    m_vld = 0; m_we = 0; m_err = 1;
                end else begin
                    m_addr = m_a; m_we = bus.we_in[m_owner]; m_vld = 1;
                end
                m_rel = bus.last[m_owner];
            end else begin
                m_vld = 0;
                m_we  = 0;
                m_idle++;
                m_rel = (m_idle == TIMEOUT);
            end
            if (m_rel) begin
                m_ptr  = (m_owner + 1) % NSRC;
                m_busy = 0;
                m_idle = 0;
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n && cmp_en) begin
            check("gnt",      int'(bus.gnt),          m_busy ? (1 << m_owner) : 0);
            check("vld",      int'(bus.regffte_vld),  int'(m_vld));
            check("we",       int'(bus.regffte_we),   int'(m_we));
            check("addr",     int'(bus.regffte_addr), m_addr);
            check("cur_src",  int'(bus.cur_src),      m_owner);
            check("addr_err", int'(bus.addr_err),     int'(m_err));
        end
    end

    task automatic step(input logic [1:0] r, input logic [1:0] l,
                        input int a0, input int a1, input logic [1:0] w);
        bus.req     = r;
        bus.last    = l;
        bus.addr_in = {AW'(a1), AW'(a0)};
        bus.we_in   = w;
        @(posedge clk);
        #2;
    endtask

    initial begin
        int exp_src;
        bus.req = '0; bus.last = '0; bus.addr_in = '0; bus.we_in = '0;
        #1 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        check("rst_gnt",  int'(bus.gnt), 0);
        check("rst_vld",  int'(bus.regffte_vld), 0);
        check("rst_addr", int'(bus.regffte_addr), 0);
        check("rst_err",  int'(bus.addr_err), 0);
        rst_n  = 1'b1;
        cmp_en = 1'b1;

        // src0 burst 5,6,7
        step(2'b01, 2'b00, 5, 0, 2'b00);
        check("t2_gnt", int'(bus.gnt), 1);
        check("t2_bubble_vld", int'(bus.regffte_vld), 0);
        step(2'b01, 2'b00, 5, 0, 2'b00);
        check("t2_addr5", int'(bus.regffte_addr), 5);
        check("t2_vld5", int'(bus.regffte_vld), 1);
        step(2'b01, 2'b00, 6, 0, 2'b00);
        check("t2_addr6", int'(bus.regffte_addr), 6);
        step(2'b01, 2'b01, 7, 0, 2'b00);
        check("t2_addr7", int'(bus.regffte_addr), 7);
        check("t2_rel_gnt", int'(bus.gnt), 0);
        step(2'b00, 2'b00, 0, 0, 2'b00);
        check("t2_idle_vld", int'(bus.regffte_vld), 0);
        check("t2_hold_addr", int'(bus.regffte_addr), 7);

        // src1 burst interrupted by reset; ptr must return to 0
        step(2'b10, 2'b00, 0, 20, 2'b10);
        check("t1_gnt_src1", int'(bus.gnt), 2);
        step(2'b10, 2'b00, 0, 20, 2'b10);
        check("t1_beat_vld", int'(bus.regffte_vld), 1);
        check("t1_beat_we", int'(bus.regffte_we), 1);
        rst_n = 1'b0;
        #1;
        check("t1_rst_gnt",  int'(bus.gnt), 0);
        check("t1_rst_vld",  int'(bus.regffte_vld), 0);
        check("t1_rst_addr", int'(bus.regffte_addr), 0);
        @(posedge clk);
        #2 rst_n = 1'b1;
        step(2'b11, 2'b11, 3, 9, 2'b00);
        check("t1_ptr0_gnt", int'(bus.gnt), 1);

        // both requesting 1-beat bursts: strict alternation
        exp_src = 0;
        for (int i = 0; i < 4; i++) begin
            step(2'b11, 2'b11, 3, 9, 2'b00);
            check("t3_beat_addr", int'(bus.regffte_addr), (exp_src == 0) ? 3 : 9);
            exp_src = 1 - exp_src;
            step(2'b11, 2'b11, 3, 9, 2'b00);
            check("t3_cur_src", int'(bus.cur_src), exp_src);
            check("t3_gnt", int'(bus.gnt), 1 << exp_src);
        end
        step(2'b11, 2'b11, 3, 9, 2'b00);

        // src1 owner goes idle with src0 pending: timeout release
        step(2'b10, 2'b00, 0, 30, 2'b00);
        check("t4_gnt_src1", int'(bus.gnt), 2);
        step(2'b10, 2'b00, 0, 30, 2'b00);
        check("t4_beat", int'(bus.regffte_addr), 30);
        for (int i = 0; i < TIMEOUT - 1; i++) begin
            step(2'b01, 2'b00, 11, 0, 2'b00);
            check("t4_gap_vld", int'(bus.regffte_vld), 0);
            check("t4_gap_gnt", int'(bus.gnt), 2);
        end
        step(2'b01, 2'b00, 11, 0, 2'b00);
        check("t4_release", int'(bus.gnt), 0);
        step(2'b01, 2'b00, 11, 0, 2'b00);
        check("t4_src0_gnt", int'(bus.gnt), 1);

        // src1 req/last ignored while src0 owns
        step(2'b11, 2'b10, 11, 12, 2'b00);
        check("t6_still_src0", int'(bus.gnt), 1);
        check("t6_addr", int'(bus.regffte_addr), 11);
        step(2'b11, 2'b01, 13, 12, 2'b00);
        check("t6_rel", int'(bus.gnt), 0);
        step(2'b11, 2'b00, 13, 12, 2'b00);
        check("t6_src1_gnt", int'(bus.gnt), 2);
        step(2'b10, 2'b10, 0, 14, 2'b00);
        check("t6_addr14", int'(bus.regffte_addr), 14);

        // out-of-range write from src0
        step(2'b01, 2'b00, 50, 0, 2'b01);
        step(2'b01, 2'b01, 50, 0, 2'b01);
        check("t5_vld",  int'(bus.regffte_vld),  CHK ? 0 : 1);
        check("t5_we",   int'(bus.regffte_we),   CHK ? 0 : 1);
        check("t5_addr", int'(bus.regffte_addr), CHK ? 14 : 50);
        check("t5_err",  int'(bus.addr_err),     CHK ? 1 : 0);
        step(2'b00, 2'b00, 0, 0, 2'b00);
        step(2'b00, 2'b00, 0, 0, 2'b00);
        check("t5_err_sticky", int'(bus.addr_err), CHK ? 1 : 0);

        // random traffic against the model
        for (int i = 0; i < 3000; i++) begin
            step(2'($urandom_range(0, 3)),
                 2'(($urandom_range(0, 3) == 0) ? 2'b11 : 2'($urandom_range(0, 3) & 1)),
                 int'($urandom_range(0, 63)), int'($urandom_range(0, 63)),
                 2'($urandom_range(0, 3)));
        end
        step(2'b00, 2'b00, 0, 0, 2'b00);
        cmp_en = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
